// File: rtl/jtag_scan_engine.sv
// APB-programmed JTAG master: shifts one scan of 1..SHIFT_W bits per start command,
// driving TMS/TDO from per-bit vectors and capturing TDI into a readable buffer.
module jtag_scan_engine #(
    parameter int SHIFT_W  = 64,
    parameter int DIV_W    = 8,
    parameter int HALF_RST = 9
) (
    input  logic        pclk_i,
    input  logic        prstn_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [7:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        TCK_o,
    output logic        TMS_o,
    output logic        TDO_o,
    output logic        TDOoen_o,
    input  logic        TDI_i,
    output logic        TRSTn_o,
    output logic        jtag_ext_cg_o,
    output logic        jtag_mux_sel_o,
    output logic        irq_o
);

    localparam int unsigned NW = SHIFT_W / 32;
    localparam int unsigned LW = $clog2(SHIFT_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_LOW   = 2'd2,
        S_HIGH  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;

    logic                 r_ext_cg;
    logic                 r_mux_sel;
    logic                 r_irq_en;
    logic                 r_trstn;
    logic [DIV_W-1:0]     r_half;
    logic [LW-1:0]        r_len;
    logic                 r_done;
    logic                 r_busy_err;
    logic [SHIFT_W-1:0]   r_tdo_vec;
    logic [SHIFT_W-1:0]   r_tms_vec;
    logic [SHIFT_W-1:0]   r_cap;
    logic [DIV_W-1:0]     r_cnt;
    logic [LW-1:0]        r_idx;
    logic                 r_tck;
    logic                 r_tms;
    logic                 r_tdo;
    logic                 r_irq;
    logic [31:0]          r_prdata;

    logic                 w_rd_setup;
    logic                 w_wr;
    logic [5:0]           w_waddr;
    logic [2:0]           w_grp;
    logic [2:0]           w_k;
    logic                 w_k_ok;
    logic                 w_busy;
    logic                 w_prot_hit;
    logic                 w_drop;
    logic                 w_start;
    logic                 w_cnt_zero;
    logic                 w_last;
    logic                 w_done_set;
    logic [LW-1:0]        w_idx_nx;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_rd_setup = psel_i & ~penable_i & ~pwrite_i;
    assign w_wr       = psel_i & penable_i & pwrite_i;
    assign w_waddr    = paddr_i[7:2];
    assign w_grp      = w_waddr[5:3];
    assign w_k        = w_waddr[2:0];
    assign w_k_ok     = 32'(w_k) < NW;
    assign w_busy     = (r_state != S_IDLE);
    assign w_prot_hit = (w_waddr == 6'd1) || (w_waddr == 6'd2) || (w_waddr == 6'd4) ||
                        (((w_grp == 3'd2) || (w_grp == 3'd3)) && w_k_ok);
    assign w_drop     = w_wr & w_busy & w_prot_hit;
    assign w_start    = w_wr & ~w_busy & (w_waddr == 6'd4) & pwdata_i[0];
    assign w_cnt_zero = (r_cnt == '0);
    assign w_last     = (r_idx == r_len);
    assign w_done_set = (r_state == S_HIGH) & w_cnt_zero & w_last;
    assign w_idx_nx   = r_idx + 1'b1;
    assign w_unused   = ^paddr_i[1:0];

    assign prdata_o       = r_prdata;
    assign pready_o       = 1'b1;
    assign pslverr_o      = w_drop;
    assign TCK_o          = r_tck;
    assign TMS_o          = r_tms;
    assign TDO_o          = r_tdo;
    assign TDOoen_o       = 1'b1;
    assign TRSTn_o        = r_trstn;
    assign jtag_ext_cg_o  = r_ext_cg;
    assign jtag_mux_sel_o = r_mux_sel;
    assign irq_o          = r_irq;

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nx = S_SETUP;
            S_SETUP: w_state_nx = S_LOW;
            S_LOW:   if (w_cnt_zero) w_state_nx = S_HIGH;
            S_HIGH:  if (w_cnt_zero) w_state_nx = w_last ? S_IDLE : S_LOW;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_grp)
            3'd0: begin
                case (w_k)
                    3'd0: w_rdata = {15'd0, r_trstn, 7'd0, r_irq_en, 6'd0, r_mux_sel, r_ext_cg};
                    3'd1: w_rdata = 32'(r_half);
                    3'd2: w_rdata = 32'(r_len);
                    3'd3: w_rdata = {29'd0, r_busy_err, r_done, w_busy};
                    default: w_rdata = '0;
                endcase
            end
            3'd2, 3'd3, 3'd4: begin
                for (int unsigned w = 0; w < NW; w++) begin
                    if (32'(w_k) == w) begin
                        if (w_grp == 3'd2)      w_rdata = r_tdo_vec[w*32 +: 32];
                        else if (w_grp == 3'd3) w_rdata = r_tms_vec[w*32 +: 32];
                        else                    w_rdata = r_cap[w*32 +: 32];
                    end
                end
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            r_ext_cg   <= 1'b0;
            r_mux_sel  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_trstn    <= 1'b1;
            r_half     <= DIV_W'(HALF_RST);
            r_len      <= '0;
            r_done     <= 1'b0;
            r_busy_err <= 1'b0;
            r_tdo_vec  <= '0;
            r_tms_vec  <= '0;
            r_cap      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tck      <= 1'b0;
            r_tms      <= 1'b0;
            r_tdo      <= 1'b0;
            r_irq      <= 1'b0;
            r_prdata   <= '0;
        end else begin
            r_prdata <= w_rd_setup ? w_rdata : '0;
            r_irq    <= r_done & r_irq_en;

            if (w_wr && (w_waddr == 6'd0)) begin
                r_ext_cg  <= pwdata_i[0];
                r_mux_sel <= pwdata_i[1];
                r_irq_en  <= pwdata_i[8];
                r_trstn   <= pwdata_i[16];
            end
            if (w_wr && !w_busy) begin
                if (w_waddr == 6'd1) r_half <= pwdata_i[DIV_W-1:0];
                if (w_waddr == 6'd2) r_len  <= pwdata_i[LW-1:0];
                for (int unsigned w = 0; w < NW; w++) begin
                    if (32'(w_k) == w) begin
                        if (w_grp == 3'd2) r_tdo_vec[w*32 +: 32] <= pwdata_i;
                        if (w_grp == 3'd3) r_tms_vec[w*32 +: 32] <= pwdata_i;
                    end
                end
            end

            // Sticky status: a set in the same cycle as a W1C clear wins.
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr && (w_waddr == 6'd3) && pwdata_i[1])
                r_done <= 1'b0;
            if (w_drop)
                r_busy_err <= 1'b1;
            else if (w_wr && (w_waddr == 6'd3) && pwdata_i[2])
                r_busy_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) r_cap <= '0;
                end
                S_SETUP: begin
                    r_tms <= r_tms_vec[0];
                    r_tdo <= r_tdo_vec[0];
                    r_tck <= 1'b0;
                    r_cnt <= r_half;
                    r_idx <= '0;
                end
                S_LOW: begin
                    if (w_cnt_zero) begin
                        r_tck        <= 1'b1;
                        r_cap[r_idx] <= TDI_i;
                        r_cnt        <= r_half;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_cnt_zero) begin
                        r_tck <= 1'b0;
                        if (!w_last) begin
                            r_idx <= w_idx_nx;
                            r_tms <= r_tms_vec[w_idx_nx];
                            r_tdo <= r_tdo_vec[w_idx_nx];
                            r_cnt <= r_half;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
